// File: rtl/operand_fetch.sv
// Operand-fetch stage: drives register-file reads, bypasses same-edge writeback,
// and keeps presented operands coherent with writes that land while stalled.
module operand_fetch #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 8,
  parameter bit ZERO_REG   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_rs1,
  input  logic [ADDR_WIDTH-1:0] in_rs2,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic [ADDR_WIDTH-1:0] rf_rd_addr1,
  output logic [ADDR_WIDTH-1:0] rf_rd_addr2,
  input  logic [DATA_WIDTH-1:0] rf_rd_data1,
  input  logic [DATA_WIDTH-1:0] rf_rd_data2,
  input  logic                  wb_en,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_op1,
  output logic [DATA_WIDTH-1:0] out_op2,
  output logic [ADDR_WIDTH-1:0] out_rs1,
  output logic [ADDR_WIDTH-1:0] out_rs2,
  output logic [TAG_WIDTH-1:0]  out_tag
);

  typedef enum logic [1:0] {S_EMPTY, S_FRESH, S_HELD} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_out_valid;
  logic [ADDR_WIDTH-1:0] r_rs1, r_rs2;
  logic [TAG_WIDTH-1:0]  r_tag;
  logic                  r_byp1, r_byp2;
  logic [DATA_WIDTH-1:0] r_bdata1, r_bdata2;
  logic [DATA_WIDTH-1:0] r_hold1, r_hold2;
  logic                  w_accept;
  logic                  w_zero1, w_zero2;
  logic [DATA_WIDTH-1:0] w_op1, w_op2;

  // FRESH takes the register-file data unless a write hit the same edge as accept.
  function automatic logic [DATA_WIDTH-1:0] sel_op(
    input state_t                st,
    input logic                  zero,
    input logic                  byp,
    input logic [DATA_WIDTH-1:0] bdata,
    input logic [DATA_WIDTH-1:0] rfd,
    input logic [DATA_WIDTH-1:0] hold
  );
    logic [DATA_WIDTH-1:0] v;
    v = '0;
    if (!zero) begin
      if (st == S_FRESH)     v = byp ? bdata : rfd;
      else if (st == S_HELD) v = hold;
    end
    return v;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] hold_nxt(
    input logic                  zero,
    input logic [ADDR_WIDTH-1:0] rs,
    input logic [DATA_WIDTH-1:0] cur
  );
    return (wb_en && (wb_addr == rs) && !zero) ? wb_data : cur;
  endfunction

  assign in_ready    = !rst && ((r_state == S_EMPTY) || out_ready);
  assign w_accept    = in_valid && in_ready;
  assign rf_rd_addr1 = in_rs1;
  assign rf_rd_addr2 = in_rs2;

  assign w_zero1 = ZERO_REG && (r_rs1 == '0);
  assign w_zero2 = ZERO_REG && (r_rs2 == '0);
  assign w_op1   = sel_op(r_state, w_zero1, r_byp1, r_bdata1, rf_rd_data1, r_hold1);
  assign w_op2   = sel_op(r_state, w_zero2, r_byp2, r_bdata2, rf_rd_data2, r_hold2);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_EMPTY: if (w_accept) w_state_nxt = S_FRESH;
      default: begin
        if (out_ready) w_state_nxt = w_accept ? S_FRESH : S_EMPTY;
        else           w_state_nxt = S_HELD;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_EMPTY;
      r_out_valid <= 1'b0;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_tag       <= '0;
      r_byp1      <= 1'b0;
      r_byp2      <= 1'b0;
      r_bdata1    <= '0;
      r_bdata2    <= '0;
      r_hold1     <= '0;
      r_hold2     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_out_valid <= (w_state_nxt != S_EMPTY);
      if (w_accept) begin
        r_rs1    <= in_rs1;
        r_rs2    <= in_rs2;
        r_tag    <= in_tag;
        r_byp1   <= wb_en && (wb_addr == in_rs1);
        r_byp2   <= wb_en && (wb_addr == in_rs2);
        r_bdata1 <= wb_data;
        r_bdata2 <= wb_data;
      end
      // Stalled: fold in any write that lands on the presented sources.
      if ((r_state != S_EMPTY) && !out_ready) begin
        r_hold1 <= hold_nxt(w_zero1, r_rs1, w_op1);
        r_hold2 <= hold_nxt(w_zero2, r_rs2, w_op2);
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_op1   = w_op1;
  assign out_op2   = w_op2;
  assign out_rs1   = r_rs1;
  assign out_rs2   = r_rs2;
  assign out_tag   = r_tag;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: register-file model plus a transaction-level reference
// (presented operands always equal the current architectural register values).
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [4:0]  in_rs1, in_rs2;
  logic [7:0]  in_tag;
  logic [4:0]  rf_rd_addr1, rf_rd_addr2;
  logic [31:0] rf_rd_data1, rf_rd_data2;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        out_valid, out_ready;
  logic [31:0] out_op1, out_op2;
  logic [4:0]  out_rs1, out_rs2;
  logic [7:0]  out_tag;

  operand_fetch #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .TAG_WIDTH(8), .ZERO_REG(1'b1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_tag(in_tag),
    .rf_rd_addr1(rf_rd_addr1), .rf_rd_addr2(rf_rd_addr2),
    .rf_rd_data1(rf_rd_data1), .rf_rd_data2(rf_rd_data2),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op1(out_op1), .out_op2(out_op2),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  // Register file: registered read returning the pre-write value; r0 is stored
  // like any other index so only the stage itself can force it to zero.
  logic [31:0] mem [32];
  always @(posedge clk) begin
    rf_rd_data1 <= mem[rf_rd_addr1];
    rf_rd_data2 <= mem[rf_rd_addr2];
    if (wb_en) mem[wb_addr] <= wb_data;
  end

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [7:0] tag;
  } req_t;

  req_t q[$];
  int   ncmp = 0;
  int   nerr = 0;

  function automatic logic [31:0] arch(input logic [4:0] rs);
    return (rs == 5'd0) ? 32'h0 : mem[rs];
  endfunction

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, check the presented
  // state against the reference, then advance the reference across the next edge.
  task automatic cyc(input logic v, input logic [4:0] a1, input logic [4:0] a2,
                     input logic [7:0] t, input logic we, input logic [4:0] wa,
                     input logic [31:0] wd, input logic ordy);
    logic acc;
    @(negedge clk);
    in_valid = v; in_rs1 = a1; in_rs2 = a2; in_tag = t;
    wb_en = we; wb_addr = wa; wb_data = wd; out_ready = ordy;
    #1;
    chk("out_valid", {31'b0, out_valid}, {31'b0, q.size() != 0});
    if (q.size() != 0) begin
      chk("out_rs1", {27'b0, out_rs1}, {27'b0, q[0].rs1});
      chk("out_rs2", {27'b0, out_rs2}, {27'b0, q[0].rs2});
      chk("out_tag", {24'b0, out_tag}, {24'b0, q[0].tag});
      chk("out_op1", out_op1, arch(q[0].rs1));
      chk("out_op2", out_op2, arch(q[0].rs2));
    end
    chk("in_ready", {31'b0, in_ready}, {31'b0, (q.size() == 0) || ordy});
    chk("rf_rd_addr1", {27'b0, rf_rd_addr1}, {27'b0, a1});
    chk("rf_rd_addr2", {27'b0, rf_rd_addr2}, {27'b0, a2});
    acc = v && ((q.size() == 0) || ordy);
    if ((q.size() != 0) && ordy) void'(q.pop_front());
    if (acc) q.push_back('{rs1: a1, rs2: a2, tag: t});
  endtask

  task automatic peek(input string name, input logic [31:0] e1, input logic [31:0] e2);
    @(posedge clk);
    #1;
    chk({name, "_op1"}, out_op1, e1);
    chk({name, "_op2"}, out_op2, e2);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    rst = 1'b1;
    in_valid = 1'b0; in_rs1 = '0; in_rs2 = '0; in_tag = '0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0; out_ready = 1'b0;
    #3;
    chk("rst_in_ready", {31'b0, in_ready}, 32'h0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_out_op1", out_op1, 32'h0);
    chk("rst_out_tag", {24'b0, out_tag}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Same-edge RAW: r5 is still 0 in the register file.
    cyc(1'b1, 5'd5, 5'd6, 8'h31, 1'b1, 5'd5, 32'hDEADBEEF, 1'b1);
    peek("raw", 32'hDEADBEEF, 32'h0);

    // Basic read.
    cyc(1'b0, 5'd0, 5'd0, 8'h00, 1'b1, 5'd3, 32'h11, 1'b1);
    cyc(1'b0, 5'd0, 5'd0, 8'h00, 1'b1, 5'd4, 32'h22, 1'b1);
    cyc(1'b1, 5'd3, 5'd4, 8'h5A, 1'b0, 5'd0, 32'h0, 1'b1);
    peek("basic", 32'h11, 32'h22);
    chk("basic_tag", {24'b0, out_tag}, 32'h5A);

    // Stall with a write to r7 during the second stall cycle.
    cyc(1'b1, 5'd2, 5'd7, 8'h70, 1'b0, 5'd0, 32'h0, 1'b1);
    cyc(1'b1, 5'd9, 5'd9, 8'h71, 1'b0, 5'd0, 32'h0, 1'b0);
    cyc(1'b1, 5'd9, 5'd9, 8'h71, 1'b1, 5'd7, 32'hA5A5A5A5, 1'b0);
    peek("stall", 32'h0, 32'hA5A5A5A5);
    cyc(1'b1, 5'd9, 5'd9, 8'h71, 1'b0, 5'd0, 32'h0, 1'b0);
    cyc(1'b1, 5'd9, 5'd9, 8'h71, 1'b0, 5'd0, 32'h0, 1'b1);

    // Zero register, including a concurrent write to r0.
    cyc(1'b1, 5'd0, 5'd0, 8'h00, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1);
    peek("zero", 32'h0, 32'h0);
    cyc(1'b1, 5'd0, 5'd3, 8'h01, 1'b0, 5'd0, 32'h0, 1'b1);
    peek("zero_rf", 32'h0, 32'h11);

    // Back-to-back, then toggling out_ready.
    for (int i = 0; i < 8; i++)
      cyc(1'b1, 5'(i), 5'(i + 8), 8'(8'h80 + i), 1'b0, 5'd0, 32'h0, 1'b1);
    for (int i = 0; i < 16; i++)
      cyc(1'b1, 5'(i % 8), 5'(7 - i % 8), 8'(8'hC0 + i), 1'b1, 5'(i % 8),
          32'(32'h1000 + i), i[0]);

    // Randomized traffic with dense address collisions.
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
          8'($urandom), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
          32'($urandom), 1'($urandom_range(0, 9) < 7));

    // Reset while held.
    cyc(1'b0, 5'd0, 5'd0, 8'h00, 1'b0, 5'd0, 32'h0, 1'b1);
    cyc(1'b1, 5'd3, 5'd4, 8'h77, 1'b0, 5'd0, 32'h0, 1'b1);
    cyc(1'b0, 5'd0, 5'd0, 8'h00, 1'b0, 5'd0, 32'h0, 1'b0);
    cyc(1'b0, 5'd0, 5'd0, 8'h00, 1'b0, 5'd0, 32'h0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("mid_rst_out_op1", out_op1, 32'h0);
    chk("mid_rst_out_op2", out_op2, 32'h0);
    chk("mid_rst_in_ready", {31'b0, in_ready}, 32'h0);
    chk("mid_rst_out_rs1", {27'b0, out_rs1}, 32'h0);
    chk("mid_rst_out_tag", {24'b0, out_tag}, 32'h0);
    q.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc(1'b1, 5'd3, 5'd4, 8'h78, 1'b0, 5'd0, 32'h0, 1'b1);
    peek("post_rst", arch(5'd3), arch(5'd4));
    cyc(1'b0, 5'd0, 5'd0, 8'h00, 1'b0, 5'd0, 32'h0, 1'b1);
    cyc(1'b0, 5'd0, 5'd0, 8'h00, 1'b0, 5'd0, 32'h0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
# operand_fetch

Operand-fetch stage sitting directly downstream of the 2R1W register file, between decode and execute. Accepts a source-register pair over a valid/ready handshake, drives the register file read addresses, and presents both operands one cycle later. Covers the register file's one-cycle registered read and its lack of write-through by bypassing writeback data. Keeps operands coherent with writes that land while the output is stalled.

## Interface
- ADDR_WIDTH, 5, register index width; register file depth is 2**ADDR_WIDTH
- DATA_WIDTH, 32, operand width
- TAG_WIDTH, 8, opaque sideband carried alongside the operands (decoded instruction fields)
- ZERO_REG, 1, when 1 index 0 reads as zero and ignores writes
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  stage can accept a request this cycle
- in_rs1  in  ADDR_WIDTH  source register 1
- in_rs2  in  ADDR_WIDTH  source register 2
- in_tag  in  TAG_WIDTH  sideband
- rf_rd_addr1  out  ADDR_WIDTH  register file read port 1 address
- rf_rd_addr2  out  ADDR_WIDTH  register file read port 2 address
- rf_rd_data1  in  DATA_WIDTH  register file read data 1, one cycle after the address
- rf_rd_data2  in  DATA_WIDTH  register file read data 2, one cycle after the address
- wb_en  in  1  writeback strobe; same signal that drives the register file write enable
- wb_addr  in  ADDR_WIDTH  writeback index
- wb_data  in  DATA_WIDTH  writeback data
- out_valid  out  1  operands valid
- out_ready  in  1  execute accepts operands
- out_op1  out  DATA_WIDTH  operand 1
- out_op2  out  DATA_WIDTH  operand 2
- out_rs1, out_rs2  out  ADDR_WIDTH  source indices of the presented request
- out_tag  out  TAG_WIDTH  sideband of the presented request

## Operation
- Accept = in_valid && in_ready. in_ready = !rst && (state==EMPTY || out_ready). Combinational.
- rf_rd_addr1/2 = in_rs1/2, combinational passthrough, every cycle.
- On accept, register in_rs1/2 and in_tag. For each operand, capture bypass flag byp = wb_en && wb_addr==rs, and byp_data = wb_data. The register file returns the pre-write value for a same-edge read/write.
- States:
  - EMPTY: out_valid=0.
  - FRESH: first cycle of a request. out_opN = zero-override ? 0 : bypN ? byp_dataN : rf_rd_dataN.
  - HELD: stalled at least one cycle. out_opN = holdN.
- Transitions:
  - EMPTY -> FRESH on accept.
  - FRESH/HELD with out_ready: -> FRESH if accept, else -> EMPTY.
  - FRESH/HELD without out_ready: -> HELD.
- Hold update, every edge in FRESH or HELD without out_ready: holdN <= (wb_en && wb_addr==out_rsN && !zero-override) ? wb_data : out_opN. A write landing during a stall is therefore reflected the next cycle.
- Zero override: ZERO_REG==1 && rsN==0. Forces operand 0 in all states and ignores any matching write.
- Both operands are evaluated independently; rs1==rs2 yields identical operands.
- wb_en with no pending match has no effect.

## Timing
- Latency: accept at edge N gives out_valid=1 with operands in cycle N+1. Throughput is one request per cycle with out_ready held high.
- No combinational path from wb_* to out_op*. Bypass and hold values come from registers; only rf_rd_data passes combinationally to out_op in FRESH.
- in_ready depends combinationally on out_ready. No loop exists because out_ready must not depend on in_*.
- Reset (async, any cycle, including mid-stall): state=EMPTY, out_valid=0, in_ready=0 while rst is high, hold/byp/out_rs/out_tag=0, so out_op=0. Any in-flight request is dropped. The first accept is possible in the first cycle after rst deasserts.
- Write at the same edge as accept to rs: the operand shows wb_data in FRESH. Write at the same edge as FRESH->HELD: HELD shows the new value. Write at the same edge as consumption: no effect on the consumed request; a simultaneously accepted request captures it via byp.

## Test plan
- Basic: RF r3=0x11, r4=0x22; accept rs1=3, rs2=4, out_ready=1 -> next cycle out_valid=1, op1=0x11, op2=0x22, out_tag echoed.
- Same-edge RAW: accept rs1=5 while wb_en=1, wb_addr=5, wb_data=0xDEADBEEF (old r5=0) -> FRESH op1=0xDEADBEEF.
- Stall write: request rs2=7 presented, out_ready=0 for 3 cycles, write r7=0xA5A5A5A5 in stall cycle 2 -> op2=0xA5A5A5A5 from the following cycle. in_ready=0 throughout; the op is consumed when out_ready=1.
- Zero register: ZERO_REG=1, rs1=0, rs2=0, concurrent wb_en to r0 data 0xFFFFFFFF -> op1=op2=0.
- Back-to-back: 8 requests with in_valid=1 and out_ready=1 -> 8 consecutive out_valid cycles in order. Toggling out_ready 1/0 -> no loss or duplication, and operands match the reference model.
- Reset mid-stall: rst pulsed while in HELD -> out_valid=0 and outputs 0 immediately. After release, a new request completes normally.
